alu_writeback_stage: RTL and testbench
======================================

# alu_writeback_stage

Execute-to-writeback buffer directly downstream of the 32-bit ALU. Captures each ALU result with its destination register and flags into a 2-entry in-order queue. Drains the queue to the register-file write port under a ready handshake. Maintains the architectural flags register that feeds back to the ALU `flags_in`, and gives the operand stage a forwarding lookup for results that are still in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, result/data width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ALU result valid
- in_ready  out  1  queue can accept an entry
- in_result  in  DATA_WIDTH  ALU `result`
- in_flags  in  8  ALU `flags_out`
- in_opcode  in  7  opcode of the instruction
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_wb_en  in  1  instruction writes rd
- rf_we  out  1  register-file write request
- rf_ready  in  1  register file accepts the write this cycle
- rf_waddr  out  REG_ADDR_WIDTH  write address
- rf_wdata  out  DATA_WIDTH  write data
- flags_reg  out  8  architectural flags, wired to ALU `flags_in`
- q_rs1, q_rs2  in  REG_ADDR_WIDTH  forwarding query indices
- fwd1_hit, fwd2_hit  out  1  query matches an in-flight entry
- fwd1_data, fwd2_data  out  DATA_WIDTH  forwarded value; 0 when no hit

## Operation
- Storage: 2 entries {result, flags, opcode, rd, wb_en}, head/tail pointers of 1 bit each, count 0..2. Pointers wrap modulo 2.
- Push: on `in_valid && in_ready`, write at tail, then tail++ and count++.
- `in_ready = (count != 2)`, from registered count only. There is no pass-through when full. A push and a pop in the same cycle while full cannot occur.
- Head retire, when count > 0:
  - If head `wb_en==1` and `rd!=0`: `rf_we=1`, with `rf_waddr` and `rf_wdata` taken from the head. The entry pops on `rf_we && rf_ready`.
  - Otherwise (no writeback, or rd=x0): `rf_we=0` and the entry pops unconditionally in that cycle.
- Flags update on pop: if the head opcode is 0x33 or 0x13, `flags_reg <= head flags`. Any other opcode leaves `flags_reg` unchanged.
- Simultaneous push and pop (count 1): count stays 1, both pointers advance.
- Forwarding (combinational):
  - Scan valid entries with `wb_en && rd!=0 && rd==q_rsN`.
  - When both entries match, the youngest (tail-1) wins.
  - A query of x0 never hits.
- `rf_wdata` and `rf_waddr` read 0 when `rf_we=0`.

## Timing
- Reset values (async, immediate on rst rising):
  - count=0, head=tail=0
  - in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0
  - flags_reg=0, fwd*_hit=0, fwd*_data=0
- Latency: an entry accepted at edge N presents `rf_we` in cycle N+1 (after edge N). With `rf_ready=1` it pops at edge N+1.
- Throughput: 1 entry/cycle while `rf_ready` stays high.
- Backpressure: with `rf_ready=0` and a writing head, the queue fills after 2 pushes and `in_ready` drops the cycle after the second push.
- `rf_we`, `rf_waddr`, `rf_wdata` stay stable while `rf_we && !rf_ready`.
- Reset mid-operation: all entries are discarded and no write is issued. `flags_reg` returns to 0.
- `flags_reg` changes only at the edge that pops a qualifying entry, so the ALU sees new flags from the next cycle.

## Configuration
- `WB_FLAGS_REG_EN` defined: flags register is implemented as described in Operation.
- `WB_FLAGS_REG_EN` undefined:
  - No flag storage in the queue; `in_flags` is ignored.
  - `flags_reg` is constant 0.
  - All other behaviour is identical.

## Test plan
- Reset then single push of ADD result 0x0000_0005, rd=3, wb_en=1, rf_ready=1 -> `rf_we=1`, waddr=3, wdata=5 in the next cycle, then count=0.
- rf_ready=0, push three back-to-back entries -> first two accepted, `in_ready=0` after the second. Raise rf_ready -> writes retire in order, one per cycle.
- Push with rd=0, wb_en=1, data 0xDEAD_BEEF -> `rf_we` never asserts, entry drains in 1 cycle, and with flags 0x02 on opcode 0x33 `flags_reg=0x02`.
- Two in-flight entries, both rd=7 with data 0x11 then 0x22, q_rs1=7, q_rs2=0 -> fwd1_hit=1, fwd1_data=0x22, fwd2_hit=0, fwd2_data=0.
- Opcode 0x37 (LUI) entry with flags 0x04 after flags_reg=0x02 -> flags_reg stays 0x02. Without `WB_FLAGS_REG_EN`, flags_reg=0 throughout.
- Assert rst while count=2 and rf_ready=0 -> outputs return to reset values immediately, and no write occurs after release.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback buffer: 2-entry in-order queue draining ALU results to the register file,
// with in-flight forwarding lookup. Optional architectural flags register enabled by WB_FLAGS_REG_EN.
module alu_writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [7:0]                in_flags,
    input  logic [6:0]                in_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_wb_en,
    output logic                      rf_we,
    input  logic                      rf_ready,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic [7:0]                flags_reg,
    input  logic [REG_ADDR_WIDTH-1:0] q_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] q_rs2,
    output logic                      fwd1_hit,
    output logic                      fwd2_hit,
    output logic [DATA_WIDTH-1:0]     fwd1_data,
    output logic [DATA_WIDTH-1:0]     fwd2_data
);

    logic [1:0]                count_reg;
    logic [1:0]                count_next;
    logic                      head_reg;
    logic                      tail_reg;

    logic [DATA_WIDTH-1:0]     result_mem [2];
    logic [REG_ADDR_WIDTH-1:0] rd_mem     [2];
    logic [1:0]                wb_en_mem;

    logic                      push;
    logic                      pop;
    logic                      head_writes;

    logic [1:0]                entry_valid;
    logic [1:0]                match1;
    logic [1:0]                match2;
    logic                      young_idx;

    assign in_ready    = (count_reg != 2'd2);
    assign push        = in_valid && in_ready;
    assign head_writes = (count_reg != 2'd0) && wb_en_mem[head_reg] && (rd_mem[head_reg] != '0);
    // Non-writing heads (wb_en=0 or rd=x0) retire without waiting on the register file.
    assign pop         = (count_reg != 2'd0) && (!head_writes || rf_ready);

    assign rf_we    = head_writes;
    assign rf_waddr = head_writes ? rd_mem[head_reg]     : '0;
    assign rf_wdata = head_writes ? result_mem[head_reg] : '0;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) tail_reg <= ~tail_reg;
            if (pop)  head_reg <= ~head_reg;
        end
    end

    // Payload storage needs no reset: validity is carried entirely by count/head.
    always_ff @(posedge clk) begin
        if (push) begin
            result_mem[tail_reg] <= in_result;
            rd_mem[tail_reg]     <= in_rd;
            wb_en_mem[tail_reg]  <= in_wb_en;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            assign entry_valid[gi] = (count_reg == 2'd2) ||
                                     ((count_reg == 2'd1) && (head_reg == 1'(gi)));
            assign match1[gi] = entry_valid[gi] && wb_en_mem[gi] &&
                                (rd_mem[gi] != '0) && (rd_mem[gi] == q_rs1);
            assign match2[gi] = entry_valid[gi] && wb_en_mem[gi] &&
                                (rd_mem[gi] != '0) && (rd_mem[gi] == q_rs2);
        end
    endgenerate

    // Youngest entry sits just behind the tail and takes priority over the older one.
    assign young_idx = ~tail_reg;

    always_comb begin
        fwd1_hit  = |match1;
        fwd2_hit  = |match2;
        fwd1_data = '0;
        fwd2_data = '0;
        if (match1[young_idx])      fwd1_data = result_mem[young_idx];
        else if (match1[tail_reg])  fwd1_data = result_mem[tail_reg];
        if (match2[young_idx])      fwd2_data = result_mem[young_idx];
        else if (match2[tail_reg])  fwd2_data = result_mem[tail_reg];
    end

`ifdef WB_FLAGS_REG_EN
    logic [7:0] flags_mem  [2];
    logic [6:0] opcode_mem [2];
    logic       flags_load;

    always_ff @(posedge clk) begin
        if (push) begin
            flags_mem[tail_reg]  <= in_flags;
            opcode_mem[tail_reg] <= in_opcode;
        end
    end

    // Only OP (0x33) and OP-IMM (0x13) results update the architectural flags.
    assign flags_load = pop && ((opcode_mem[head_reg] == 7'h33) || (opcode_mem[head_reg] == 7'h13));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_reg <= 8'h00;
        end else if (flags_load) begin
            flags_reg <= flags_mem[head_reg];
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_flags, in_opcode};
    assign flags_reg          = 8'h00;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Table-driven bench for alu_writeback_stage plus hand-written asynchronous reset sequence.
// Expected flags follow WB_FLAGS_REG_EN; when undefined they are always 0.
module tb_alu_writeback_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [7:0]  in_flags;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        rf_we;
    logic        rf_ready;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  flags_reg;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;

    int total = 0;
    int bad   = 0;

    alu_writeback_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_flags  (in_flags),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_wb_en  (in_wb_en),
        .rf_we     (rf_we),
        .rf_ready  (rf_ready),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .flags_reg (flags_reg),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] res;
        logic [7:0]  flg;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        wb;
        logic        rdy;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        e_in_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
        logic [7:0]  e_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] vld, input logic [31:0] res, input logic [31:0] flg,
        input logic [31:0] op, input logic [31:0] rd, input logic [31:0] wb,
        input logic [31:0] rdy, input logic [31:0] q1, input logic [31:0] q2,
        input logic [31:0] e_rdy, input logic [31:0] e_we, input logic [31:0] e_wa,
        input logic [31:0] e_wd, input logic [31:0] e_h1, input logic [31:0] e_d1,
        input logic [31:0] e_h2, input logic [31:0] e_d2, input logic [31:0] e_fl);
        vec_t v;
        v.vld = vld[0];        v.res = res;           v.flg = flg[7:0];
        v.op  = op[6:0];       v.rd  = rd[4:0];       v.wb  = wb[0];
        v.rdy = rdy[0];        v.q1  = q1[4:0];       v.q2  = q2[4:0];
        v.e_in_ready = e_rdy[0]; v.e_we = e_we[0];    v.e_waddr = e_wa[4:0];
        v.e_wdata = e_wd;      v.e_h1 = e_h1[0];      v.e_d1 = e_d1;
        v.e_h2 = e_h2[0];      v.e_d2 = e_d2;         v.e_flags = e_fl[7:0];
        return v;
    endfunction

    function automatic logic [31:0] exp_flags(input logic [7:0] f);
`ifdef WB_FLAGS_REG_EN
        return {24'h0, f};
`else
        return {24'h0, f & 8'h00};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        in_result = 32'h0;
        in_flags  = 8'h0;
        in_opcode = 7'h0;
        in_rd     = 5'h0;
        in_wb_en  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rf_ready = 1'b0;
        q_rs1    = 5'd0;
        q_rs2    = 5'd0;
        drive_idle();

        // Rows: inputs applied before an edge; expectations describe outputs before that edge.
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,5,0,'h33,3,1, 1,3,0,  1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,3,0,  1,1,3,5,1,5,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,3,0,  1,0,0,0,0,0,0,0,0));
        // Backpressure: three pushes with rf_ready low, third rejected
        vecs.push_back(mk(1,'h100,'h01,'h33,1,1, 0,0,0,  1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,'h200,'h08,'h13,2,1, 0,0,0,  1,1,1,'h100,0,0,0,0,0));
        vecs.push_back(mk(1,'h300,'h40,'h33,4,1, 0,2,1,  0,1,1,'h100,1,'h200,1,'h100,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,2,4,  0,1,1,'h100,1,'h200,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,  0,1,1,'h100,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,  1,1,2,'h200,0,0,0,0,'h01));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,'h08));
        // rd=x0 drains without a write even with rf_ready low
        vecs.push_back(mk(1,'hDEADBEEF,'h02,'h33,0,1, 0,0,0,  1,0,0,0,0,0,0,0,'h08));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,  1,0,0,0,0,0,0,0,'h08));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,  1,0,0,0,0,0,0,0,'h02));
        // LUI does not touch flags
        vecs.push_back(mk(1,'h1234,'h04,'h37,5,1, 1,0,0,  1,0,0,0,0,0,0,0,'h02));
        vecs.push_back(mk(0,0,0,0,0,0, 1,5,0,  1,1,5,'h1234,1,'h1234,0,0,'h02));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,'h02));
        // wb_en=0: no write, no forward, still updates flags
        vecs.push_back(mk(1,'h55,'h10,'h13,9,0, 0,9,0,  1,0,0,0,0,0,0,0,'h02));
        vecs.push_back(mk(0,0,0,0,0,0, 0,9,0,  1,0,0,0,0,0,0,0,'h02));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,  1,0,0,0,0,0,0,0,'h10));
        // Full throughput: simultaneous push and pop at count 1
        vecs.push_back(mk(1,'hA,0,'h37,10,1, 1,0,0,  1,0,0,0,0,0,0,0,'h10));
        vecs.push_back(mk(1,'hB,0,'h37,11,1, 1,10,11,  1,1,10,'hA,1,'hA,0,0,'h10));
        vecs.push_back(mk(0,0,0,0,0,0, 1,10,11,  1,1,11,'hB,0,0,1,'hB,'h10));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,'h10));
        // Forwarding: two in-flight entries to x7, youngest wins
        vecs.push_back(mk(1,'h11,0,'h37,7,1, 0,7,0,  1,0,0,0,0,0,0,0,'h10));
        vecs.push_back(mk(1,'h22,0,'h37,7,1, 0,7,0,  1,1,7,'h11,1,'h11,0,0,'h10));
        vecs.push_back(mk(0,0,0,0,0,0, 0,7,0,  0,1,7,'h11,1,'h22,0,0,'h10));

        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_rf_we",    32'(rf_we),    32'd0);
        chk("reset_flags",    32'(flags_reg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid  = vecs[i].vld;
            in_result = vecs[i].res;
            in_flags  = vecs[i].flg;
            in_opcode = vecs[i].op;
            in_rd     = vecs[i].rd;
            in_wb_en  = vecs[i].wb;
            rf_ready  = vecs[i].rdy;
            q_rs1     = vecs[i].q1;
            q_rs2     = vecs[i].q2;
            #1;
            $display("vec %0d: vld=%b rd=%0d res=%h rdy=%b -> in_ready=%b rf_we=%b waddr=%0d wdata=%h fwd1=%b/%h fwd2=%b/%h flags=%h",
                     i, in_valid, in_rd, in_result, rf_ready, in_ready, rf_we, rf_waddr, rf_wdata,
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, flags_reg);
            chk("in_ready",  32'(in_ready),  32'(vecs[i].e_in_ready));
            chk("rf_we",     32'(rf_we),     32'(vecs[i].e_we));
            chk("rf_waddr",  32'(rf_waddr),  32'(vecs[i].e_waddr));
            chk("rf_wdata",  rf_wdata,       vecs[i].e_wdata);
            chk("fwd1_hit",  32'(fwd1_hit),  32'(vecs[i].e_h1));
            chk("fwd1_data", fwd1_data,      vecs[i].e_d1);
            chk("fwd2_hit",  32'(fwd2_hit),  32'(vecs[i].e_h2));
            chk("fwd2_data", fwd2_data,      vecs[i].e_d2);
            chk("flags_reg", 32'(flags_reg), exp_flags(vecs[i].e_flags));
        end

        // Queue now holds two entries with rf_ready low; reset asynchronously mid-cycle.
        @(negedge clk);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: in_ready=%b rf_we=%b waddr=%0d wdata=%h fwd1=%b/%h flags=%h",
                 in_ready, rf_we, rf_waddr, rf_wdata, fwd1_hit, fwd1_data, flags_reg);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_rf_we",     32'(rf_we),     32'd0);
        chk("arst_rf_waddr",  32'(rf_waddr),  32'd0);
        chk("arst_rf_wdata",  rf_wdata,       32'd0);
        chk("arst_fwd1_hit",  32'(fwd1_hit),  32'd0);
        chk("arst_fwd1_data", fwd1_data,      32'd0);
        chk("arst_flags",     32'(flags_reg), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        rf_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            $display("post-reset cycle %0d: rf_we=%b in_ready=%b", c, rf_we, in_ready);
            chk("post_rst_rf_we",    32'(rf_we),    32'd0);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end

        // Queue still works after reset.
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = 32'h66;
        in_opcode = 7'h37;
        in_rd     = 5'd6;
        in_wb_en  = 1'b1;
        @(negedge clk);
        drive_idle();
        #1;
        $display("post-reset push: rf_we=%b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
        chk("post_push_rf_we",    32'(rf_we),    32'd1);
        chk("post_push_rf_waddr", 32'(rf_waddr), 32'd6);
        chk("post_push_rf_wdata", rf_wdata,      32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
